// File: rtl/next_pc_ctrl_pkg.sv
// Shared encodings and default addresses for the fetch next-PC controller.
// The branch type codes match the br_type_i field decoded in the D stage.
package next_pc_ctrl_pkg;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'd0,
      BR_BNE  = 3'd1,
      BR_BLEZ = 3'd2,
      BR_BGTZ = 3'd3,
      BR_BLTZ = 3'd4,
      BR_BGEZ = 3'd5,
      BR_J    = 3'd6,
      BR_JR   = 3'd7
   } br_type_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } pc_state_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

endpackage

// File: rtl/next_pc_ctrl_branch_cmp.sv
// Combinational branch resolution: taken decision on forwarded operands plus
// target address generation for PC-relative branches, J and JR.
module branch_cmp
   import next_pc_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_valid,
   input  logic [2:0]       i_type,
   input  logic [WIDTH-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rt,
   input  logic [25:0]      i_imm26,
   input  logic [WIDTH-1:0] i_pc4,
   output logic             o_taken,
   output logic [WIDTH-1:0] o_target
);

   br_type_e         w_type;
   logic             w_rs_neg;
   logic             w_rs_zero;
   logic [WIDTH-1:0] w_br_off;
   logic [WIDTH-1:0] w_br_tgt;
   logic [WIDTH-1:0] w_j_tgt;

   assign w_type    = br_type_e'(i_type);
   assign w_rs_neg  = i_rs[WIDTH-1];
   assign w_rs_zero = (i_rs == '0);

   // Word offset, sign-extended from the low 16 bits of the instruction index.
   assign w_br_off  = {{(WIDTH-18){i_imm26[15]}}, i_imm26[15:0], 2'b00};
   assign w_br_tgt  = i_pc4 + w_br_off;
   assign w_j_tgt   = {i_pc4[WIDTH-1:28], i_imm26, 2'b00};

   always_comb begin
      o_taken  = 1'b0;
      o_target = w_br_tgt;
      case (w_type)
         BR_BEQ:  o_taken = (i_rs == i_rt);
         BR_BNE:  o_taken = (i_rs != i_rt);
         BR_BLEZ: o_taken = w_rs_neg | w_rs_zero;
         BR_BGTZ: o_taken = ~w_rs_neg & ~w_rs_zero;
         BR_BLTZ: o_taken = w_rs_neg;
         BR_BGEZ: o_taken = ~w_rs_neg;
         BR_J: begin
            o_taken  = 1'b1;
            o_target = w_j_tgt;
         end
         BR_JR: begin
            o_taken  = 1'b1;
            o_target = i_rs;
         end
         default: o_taken = 1'b0;
      endcase
      if (!i_valid) begin
         o_taken = 1'b0;
      end
   end

endmodule

// File: rtl/next_pc_ctrl.sv
// Fetch PC register and RUN/PEND controller. A transfer resolved while fetch
// is stalled is parked in r_pend_tgt and applied on the first unstalled edge.
module next_pc_ctrl
   import next_pc_ctrl_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
   parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(DEF_EXC_PC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             br_valid_i,
   input  logic [2:0]       br_type_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   input  logic [25:0]      imm26_i,
   input  logic [WIDTH-1:0] pc4_d_i,
   input  logic             exc_req_i,
   input  logic             eret_req_i,
   input  logic [WIDTH-1:0] epc_i,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] pc4_o,
   output logic             redirect_o,
   output logic             flush_o,
   output logic             pend_o,
   output logic             misalign_o
);

   pc_state_e        r_state;
   pc_state_e        w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] r_pend_tgt;
   logic [WIDTH-1:0] w_pend_tgt_nxt;
   logic             r_flush;
   logic             w_flush_nxt;
   logic             w_taken;
   logic [WIDTH-1:0] w_target;
   logic             w_taken_run;
   logic [WIDTH-1:0] w_pc_plus4;

   branch_cmp #(.WIDTH(WIDTH)) u_branch_cmp (
      .i_valid  (br_valid_i),
      .i_type   (br_type_i),
      .i_rs     (rs_i),
      .i_rt     (rt_i),
      .i_imm26  (imm26_i),
      .i_pc4    (pc4_d_i),
      .o_taken  (w_taken),
      .o_target (w_target)
   );

   // The comparator result only counts in RUN; PEND ignores the D stage.
   assign w_taken_run = w_taken && (r_state == ST_RUN);
   assign w_pc_plus4  = r_pc + WIDTH'(4);

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_pend_tgt_nxt = r_pend_tgt;
      w_flush_nxt    = 1'b0;
      if (exc_req_i) begin
         w_pc_nxt    = EXC_PC;
         w_state_nxt = ST_RUN;
         w_flush_nxt = 1'b1;
      end else if (eret_req_i) begin
         w_pc_nxt    = epc_i;
         w_state_nxt = ST_RUN;
         w_flush_nxt = 1'b1;
      end else if (stall_i) begin
         if (w_taken_run) begin
            w_pend_tgt_nxt = w_target;
            w_state_nxt    = ST_PEND;
         end
      end else if (r_state == ST_PEND) begin
         w_pc_nxt    = r_pend_tgt;
         w_state_nxt = ST_RUN;
      end else if (w_taken_run) begin
         w_pc_nxt = w_target;
      end else begin
         w_pc_nxt = w_pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_pend_tgt <= '0;
         r_flush    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_pend_tgt <= w_pend_tgt_nxt;
         r_flush    <= w_flush_nxt;
      end
   end

   assign pc_o       = r_pc;
   assign pc4_o      = w_pc_plus4;
   assign redirect_o = w_taken_run;
   assign flush_o    = r_flush;
   assign pend_o     = (r_state == ST_PEND);
   assign misalign_o = |r_pc[1:0];

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed-vector bench for next_pc_ctrl; expected values are hand-computed.
module tb_next_pc_ctrl;
   import next_pc_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        br_valid_i;
   logic [2:0]  br_type_i;
   logic [31:0] rs_i;
   logic [31:0] rt_i;
   logic [25:0] imm26_i;
   logic [31:0] pc4_d_i;
   logic        exc_req_i;
   logic        eret_req_i;
   logic [31:0] epc_i;
   logic [31:0] pc_o;
   logic [31:0] pc4_o;
   logic        redirect_o;
   logic        flush_o;
   logic        pend_o;
   logic        misalign_o;

   int n_checks = 0;
   int n_pass   = 0;

   next_pc_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .stall_i    (stall_i),
      .br_valid_i (br_valid_i),
      .br_type_i  (br_type_i),
      .rs_i       (rs_i),
      .rt_i       (rt_i),
      .imm26_i    (imm26_i),
      .pc4_d_i    (pc4_d_i),
      .exc_req_i  (exc_req_i),
      .eret_req_i (eret_req_i),
      .epc_i      (epc_i),
      .pc_o       (pc_o),
      .pc4_o      (pc4_o),
      .redirect_o (redirect_o),
      .flush_o    (flush_o),
      .pend_o     (pend_o),
      .misalign_o (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_br(input logic v, input br_type_e t, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [25:0] imm,
                           input logic [31:0] pc4);
      br_valid_i = v;
      br_type_i  = t;
      rs_i       = rs;
      rt_i       = rt;
      imm26_i    = imm;
      pc4_d_i    = pc4;
   endtask

   initial begin
      reset      = 1'b1;
      stall_i    = 1'b0;
      exc_req_i  = 1'b0;
      eret_req_i = 1'b0;
      epc_i      = '0;
      drive_br(1'b0, BR_BEQ, 32'h0, 32'h0, 26'h0, 32'h0);
      #12;
      check("reset_pc", pc_o, 32'h0000_3000);
      check("reset_pend", {31'b0, pend_o}, 32'h0);
      check("reset_flush", {31'b0, flush_o}, 32'h0);
      step();
      check("reset_hold_pc", pc_o, 32'h0000_3000);
      reset = 1'b0;

      // Sequential fetch after reset release
      step();
      check("seq_1", pc_o, 32'h0000_3004);
      step();
      check("seq_2", pc_o, 32'h0000_3008);
      step();
      check("seq_3", pc_o, 32'h0000_300C);
      check("seq_pc4", pc4_o, 32'h0000_3010);
      check("seq_flush", {31'b0, flush_o}, 32'h0);

      // BEQ taken backwards: 0x3008 + (-2 << 2) = 0x3000
      drive_br(1'b1, BR_BEQ, 32'd5, 32'd5, 26'h000_FFFE, 32'h0000_3008);
      #1 check("beq_redirect", {31'b0, redirect_o}, 32'h1);
      step();
      check("beq_pc", pc_o, 32'h0000_3000);
      check("beq_noflush", {31'b0, flush_o}, 32'h0);
      drive_br(1'b1, BR_BNE, 32'd5, 32'd5, 26'h000_FFFE, 32'h0000_3008);
      #1 check("bne_redirect", {31'b0, redirect_o}, 32'h0);
      step();
      check("bne_pc", pc_o, 32'h0000_3004);

      // J resolved under stall: parked, then applied when stall drops
      stall_i = 1'b1;
      drive_br(1'b1, BR_J, 32'h0, 32'h0, 26'h000_0C10, 32'h0000_3008);
      #1 check("j_redirect_stalled", {31'b0, redirect_o}, 32'h1);
      step();
      check("j_pend1", {31'b0, pend_o}, 32'h1);
      check("j_frozen1", pc_o, 32'h0000_3004);
      drive_br(1'b1, BR_J, 32'h0, 32'h0, 26'h000_0100, 32'h0000_3008);
      #1 check("pend_no_redirect", {31'b0, redirect_o}, 32'h0);
      step();
      check("j_pend2", {31'b0, pend_o}, 32'h1);
      check("j_frozen2", pc_o, 32'h0000_3004);
      stall_i = 1'b0;
      drive_br(1'b1, BR_BEQ, 32'd1, 32'd1, 26'h000_0040, 32'h0000_3008);
      step();
      check("j_release_pc", pc_o, 32'h0000_3040);
      check("j_release_pend", {31'b0, pend_o}, 32'h0);

      // Exception while PEND and stalled, then ERET
      stall_i = 1'b1;
      drive_br(1'b1, BR_J, 32'h0, 32'h0, 26'h000_0C10, 32'h0000_3044);
      step();
      check("exc_pre_pend", {31'b0, pend_o}, 32'h1);
      exc_req_i = 1'b1;
      drive_br(1'b0, BR_BEQ, 32'h0, 32'h0, 26'h0, 32'h0);
      step();
      check("exc_pc", pc_o, 32'h0000_4180);
      check("exc_pend", {31'b0, pend_o}, 32'h0);
      check("exc_flush", {31'b0, flush_o}, 32'h1);
      exc_req_i = 1'b0;
      stall_i   = 1'b0;
      step();
      check("exc_flush_drop", {31'b0, flush_o}, 32'h0);
      check("exc_next_pc", pc_o, 32'h0000_4184);
      eret_req_i = 1'b1;
      epc_i      = 32'h0000_3010;
      step();
      check("eret_pc", pc_o, 32'h0000_3010);
      check("eret_flush", {31'b0, flush_o}, 32'h1);
      eret_req_i = 1'b0;
      step();
      check("eret_next_pc", pc_o, 32'h0000_3014);
      check("eret_flush_drop", {31'b0, flush_o}, 32'h0);

      // Signed compares: BLTZ on most-negative, BGTZ/BGEZ boundaries
      drive_br(1'b1, BR_BLTZ, 32'h8000_0000, 32'h0, 26'h000_0004, 32'h0000_3018);
      #1 check("bltz_redirect", {31'b0, redirect_o}, 32'h1);
      step();
      check("bltz_pc", pc_o, 32'h0000_3028);
      drive_br(1'b1, BR_BGTZ, 32'h0, 32'h0, 26'h000_0004, 32'h0000_302C);
      #1 check("bgtz_zero_redirect", {31'b0, redirect_o}, 32'h0);
      drive_br(1'b1, BR_BGEZ, 32'hFFFF_FFFF, 32'h0, 26'h000_0004, 32'h0000_302C);
      #1 check("bgez_neg_redirect", {31'b0, redirect_o}, 32'h0);
      drive_br(1'b1, BR_BLEZ, 32'h0, 32'h0, 26'h000_0004, 32'h0000_302C);
      #1 check("blez_zero_redirect", {31'b0, redirect_o}, 32'h1);
      drive_br(1'b1, BR_BGTZ, 32'h0, 32'h0, 26'h000_0004, 32'h0000_302C);
      step();
      check("bgtz_pc", pc_o, 32'h0000_302C);

      // JR to a misaligned address
      drive_br(1'b1, BR_JR, 32'h0000_3002, 32'h0, 26'h0, 32'h0000_3030);
      step();
      check("jr_pc", pc_o, 32'h0000_3002);
      check("jr_misalign", {31'b0, misalign_o}, 32'h1);

      // PC+4 wraps at the top of the address space
      drive_br(1'b1, BR_JR, 32'hFFFF_FFFC, 32'h0, 26'h0, 32'h0000_3006);
      step();
      check("wrap_pre", pc_o, 32'hFFFF_FFFC);
      drive_br(1'b0, BR_BEQ, 32'h0, 32'h0, 26'h0, 32'h0);
      step();
      check("wrap_pc", pc_o, 32'h0000_0000);
      check("wrap_aligned", {31'b0, misalign_o}, 32'h0);

      // Asynchronous reset between edges while PEND
      stall_i = 1'b1;
      drive_br(1'b1, BR_J, 32'h0, 32'h0, 26'h000_0C10, 32'h0000_0008);
      step();
      check("rst_pre_pend", {31'b0, pend_o}, 32'h1);
      drive_br(1'b0, BR_BEQ, 32'h0, 32'h0, 26'h0, 32'h0);
      #2 reset = 1'b1;
      #1 check("async_rst_pc", pc_o, 32'h0000_3000);
      check("async_rst_pend", {31'b0, pend_o}, 32'h0);
      @(negedge clk);
      stall_i = 1'b0;
      reset   = 1'b0;
      step();
      check("post_rst_pc", pc_o, 32'h0000_3004);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/next_pc_ctrl.md
NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

Interface
REQ-001 Parameter WIDTH, 32, PC/data width (>=28).
REQ-002 Parameter RESET_PC, 32'h0000_3000, PC value after reset.
REQ-003 Parameter EXC_PC, 32'h0000_4180, exception handler entry.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stall_i  in  1  freeze fetch PC this cycle.
REQ-007 br_valid_i  in  1  D-stage control-transfer instruction present.
REQ-008 br_type_i  in  3  BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, J (covers JAL), JR.
REQ-009 rs_i, rt_i  in  WIDTH each  forwarded operands.
REQ-010 imm26_i  in  26  instruction index; low 16 bits are the branch offset.
REQ-011 pc4_d_i  in  WIDTH  PC+4 of the D-stage instruction.
REQ-012 exc_req_i, eret_req_i  in  1 each  exception entry / return.
REQ-013 epc_i  in  WIDTH  return address for ERET.
REQ-014 pc_o  out  WIDTH  registered fetch PC; pc4_o  out  WIDTH  pc_o+4.
REQ-015 redirect_o  out  1  combinational, high when a taken transfer is resolved this cycle in RUN.
REQ-016 flush_o  out  1  registered one-cycle pulse after exception/ERET entry.
REQ-017 pend_o  out  1  high in state PEND; misalign_o  out  1  pc_o[1:0]!=0.

Function
REQ-018 Taken: BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0; BLTZ rs<0; BGEZ rs>=0 (all signed); J, JR always.
REQ-019 Target: branches pc4_d_i + (sign-extended imm16 << 2), modulo 2^WIDTH; J {pc4_d_i[WIDTH-1:28], imm26_i, 2'b00}; JR rs_i.
REQ-020 Delay slot is architectural; a taken transfer never flushes; flush_o only for exc/ERET.
REQ-021 States RUN, PEND; PEND holds a latched target register pend_tgt.
REQ-022 Per-edge priority: exc_req_i -> pc_o<=EXC_PC, state RUN, flush_o<=1; else eret_req_i -> pc_o<=epc_i, RUN, flush_o<=1; both override stall_i.
REQ-023 Else stall_i=1: pc_o holds; if RUN and taken, pend_tgt<=target, state PEND; if PEND, stays PEND, pend_tgt unchanged.
REQ-024 Else stall_i=0 in PEND: pc_o<=pend_tgt, state RUN; br_valid_i ignored that cycle.
REQ-025 Else stall_i=0 in RUN: pc_o<=target if taken, else pc_o+4 (wraps modulo 2^WIDTH).
REQ-026 br_valid_i ignored in PEND and when br_type_i is unused encoding (treated not taken).
REQ-027 Latency: one edge from resolution to pc_o update; redirect_o valid same cycle, independent of stall_i.
REQ-028 flush_o is 0 on any edge not entering exc/ERET.
REQ-029 Misaligned targets are loaded unchanged; misalign_o flags them.

Reset
REQ-030 Assertion immediately forces pc_o=RESET_PC, state RUN, pend_tgt=0, flush_o=0, mid-operation included; pending redirect discarded.
REQ-031 First edge after deassertion follows REQ-022..025.

Structure
REQ-032 Shared package holds br_type encodings, RUN/PEND state encoding, default RESET_PC/EXC_PC constants.
REQ-033 One sub-module branch_cmp (combinational compare + target generation); FSM and PC register stay in top.

Verification
REQ-034 Reset release, no branches, 3 edges -> pc_o 0x3000, 0x3004, 0x3008, 0x300C.
REQ-035 BEQ rs=rt=5, pc4_d=0x3008, imm16=0xFFFE -> redirect_o=1, next pc_o=0x3000; BNE same operands -> pc_o+4.
REQ-036 J taken with stall_i=1 for 2 cycles, imm26=0x0000C10 -> pend_o=1, pc_o frozen, then pc_o=0x3040 when stall drops.
REQ-037 exc_req_i while PEND and stalled -> pc_o=0x4180, pend_o=0, flush_o=1 one cycle; then eret_req_i epc=0x3010 -> pc_o=0x3010.
REQ-038 BLTZ rs=0x80000000 taken, BGTZ rs=0 not taken; JR rs=0x3002 -> pc_o=0x3002, misalign_o=1.
REQ-039 reset asserted mid-PEND, between edges -> pc_o=0x3000 immediately, pend_o=0.
